core_poll_scheduler: RTL and testbench
======================================

// Module: core_poll_scheduler
// PURPOSE
// - Sweeps all hash cores in order, selecting one core at a time over the shared core_selection/save_selection lines.
// - Opens the selected core's output_enable window and samples its result from the shared bus.
// - Keeps the lowest score, the ID of the core that produced it, and that core's result word.
// - Sits between the host command interface and the array of core_id_module-selected cores.
// PARAMETERS
// - NUM_CORES     16    cores swept, IDs 0..NUM_CORES-1 (1..2^24)
// - SCORE_W       10    width of score_i (hamming distance)
// - RESULT_W      64    width of result_i (nonce / payload)
// - TIMEOUT_CYCLES 64   max WAIT cycles per core; only used with CORE_POLL_TIMEOUT_EN (>=2)
// PORTS
// - clk_i              in   1         clock
// - rst_ni             in   1         reset, asynchronous, active-low
// - start_i            in   1         pulse: begin a sweep (accepted only in IDLE)
// - abort_i            in   1         synchronous abort of the sweep in progress
// - result_valid_i     in   1         selected core presents score_i/result_i this cycle
// - score_i            in   SCORE_W   shared score bus
// - result_i           in   RESULT_W  shared result bus
// - core_selection_o   out  24        core ID being selected (idx, zero-extended)
// - save_selection_o   out  1         1-cycle latch strobe to all cores' select bits
// - output_enable_o    out  1         broadcast read enable (gated per core by its select bit)
// - busy_o             out  1         high in SELECT/WAIT
// - done_o             out  1         1-cycle pulse when a sweep completes
// - best_valid_o       out  1         best_* fields hold a sampled result
// - best_core_o        out  24        ID of the best core
// - best_score_o       out  SCORE_W   lowest score seen
// - best_result_o      out  RESULT_W  result word of the best core
// - timeout_count_o    out  8         cores skipped on timeout (saturating)
// BEHAVIOUR
// - Reset: state=IDLE, idx=0, all outputs 0, best_score_o all-ones.
// - FSM IDLE -> SELECT on start_i.
//   - Entry clears idx, best_valid_o and timeout_count_o.
//   - best_score_o is set to all-ones.
// - SELECT (exactly 1 cycle):
//   - core_selection_o=idx, save_selection_o=1, output_enable_o=0.
//   - output_enable_o is held low so no core drives the bus while the selection changes.
//   - Next state is WAIT.
// - WAIT: output_enable_o=1, save_selection_o=0, core_selection_o held.
//   - On result_valid_i, score_i/result_i are sampled.
//   - The sample is accepted as best if best_valid_o==0 or score_i < best_score_o (strict).
//   - Ties keep the lower core ID. An all-ones score is still accepted as the first best.
// - After the sample (or a timeout):
//   - If idx==NUM_CORES-1: done_o=1 for 1 cycle, go to IDLE.
//   - Otherwise: idx++, go to SELECT.
// - Per-core latency is 2 cycles minimum (SELECT + 1 WAIT). A full sweep is >= 2*NUM_CORES cycles.
// - result_valid_i is ignored outside WAIT.
// - In IDLE, output_enable_o=0 and core_selection_o holds its last value.
// - start_i while busy_o=1 is ignored.
// - abort_i in SELECT/WAIT:
//   - Next state is IDLE; output_enable_o drops the next cycle; no done_o.
//   - best_valid_o is cleared.
//   - abort_i wins over start_i and over result_valid_i in the same cycle.
// - NUM_CORES=1: the sweep is one SELECT/WAIT pair, then done_o.
// - Async reset mid-sweep returns everything to reset values immediately.
// - best_* outputs are stable between sweeps; they update only on accepted samples.
// CONFIGURATION
// - CORE_POLL_TIMEOUT_EN defined:
//   - A WAIT counter clears on WAIT entry.
//   - If TIMEOUT_CYCLES WAIT cycles pass with no result_valid_i, the core is skipped.
//   - timeout_count_o increments, saturating at 255, and the FSM advances as after a sample.
// - CORE_POLL_TIMEOUT_EN undefined: WAIT lasts until result_valid_i or abort_i. timeout_count_o tied to 0.
// TESTING
// - 4 cores with scores 9,3,7,3, valid 1 cycle after SELECT
//   -> best_core_o=1, best_score_o=3, done_o at cycle 8 after start, one pulse.
// - save_selection_o and output_enable_o never high together.
//   -> core_selection_o steps 0,1,2,3 with one save strobe per core.
// - All scores 1023 (all-ones) -> best_valid_o=1, best_core_o=0, best_score_o=1023.
// - abort_i on the same cycle as start_i in mid-sweep (core 2 WAIT) with result_valid_i high
//   -> IDLE, no done_o, best_valid_o=0.
//   - A following start_i restarts at core 0.
// - CORE_POLL_TIMEOUT_EN, TIMEOUT_CYCLES=4, core 1 never valid
//   -> core 1 skipped after 4 WAIT cycles, timeout_count_o=1, the sweep still finishes with done_o.
// - rst_ni low during WAIT -> outputs reset asynchronously; after release no activity until start_i.

Source files
------------

// File: rtl/core_poll_scheduler.sv
// Round-robin poller for the hash core array: selects each core in turn, samples its
// result and keeps the lowest score. Define CORE_POLL_TIMEOUT_EN to skip cores that never answer.
module core_poll_scheduler #(
  parameter int NUM_CORES      = 16,
  parameter int SCORE_W        = 10,
  parameter int RESULT_W       = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                result_valid_i,
  input  logic [SCORE_W-1:0]  score_i,
  input  logic [RESULT_W-1:0] result_i,
  output logic [23:0]         core_selection_o,
  output logic                save_selection_o,
  output logic                output_enable_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                best_valid_o,
  output logic [23:0]         best_core_o,
  output logic [SCORE_W-1:0]  best_score_o,
  output logic [RESULT_W-1:0] best_result_o,
  output logic [7:0]          timeout_count_o
);

  // state    | meaning
  // S_IDLE   | no sweep running, best_* stable
  // S_SELECT | broadcast idx and strobe save_selection, bus released
  // S_WAIT   | output_enable open, waiting for result_valid_i
  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_WAIT} state_t;

  localparam logic [23:0] LAST_IDX = 24'(NUM_CORES - 1);

  if (NUM_CORES < 1 || NUM_CORES > (1 << 24)) begin : g_bad_num_cores
    $error("core_poll_scheduler: NUM_CORES out of range");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("core_poll_scheduler: TIMEOUT_CYCLES must be >= 2");
  end

  state_t                state_q, state_d;
  logic [23:0]           idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  best_valid_q, best_valid_d;
  logic [23:0]           best_core_q, best_core_d;
  logic [SCORE_W-1:0]    best_score_q, best_score_d;
  logic [RESULT_W-1:0]   best_result_q, best_result_d;
  logic                  advance;

`ifdef CORE_POLL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [7:0]    tmo_cnt_q, tmo_cnt_d;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    done_d        = 1'b0;
    best_valid_d  = best_valid_q;
    best_core_d   = best_core_q;
    best_score_d  = best_score_q;
    best_result_d = best_result_q;
    advance       = 1'b0;
`ifdef CORE_POLL_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d      = S_SELECT;
          idx_d        = '0;
          best_valid_d = 1'b0;
          best_score_d = '1;
`ifdef CORE_POLL_TIMEOUT_EN
          tmo_cnt_d    = '0;
`endif
        end
      end
      S_SELECT: begin
        if (abort_i) begin
          state_d      = S_IDLE;
          best_valid_d = 1'b0;
        end else begin
          state_d = S_WAIT;
`ifdef CORE_POLL_TIMEOUT_EN
          wait_cnt_d = CW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      S_WAIT: begin
        if (abort_i) begin
          state_d      = S_IDLE;
          best_valid_d = 1'b0;
        end else if (result_valid_i) begin
          advance = 1'b1;
          // strict compare: ties keep the earlier (lower ID) core
          if (!best_valid_q || score_i < best_score_q) begin
            best_valid_d  = 1'b1;
            best_core_d   = idx_q;
            best_score_d  = score_i;
            best_result_d = result_i;
          end
        end
`ifdef CORE_POLL_TIMEOUT_EN
        else if (wait_cnt_q == '0) begin
          advance = 1'b1;
          if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
        end else begin
          wait_cnt_d = wait_cnt_q - CW'(1);
        end
`endif
        if (advance) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SELECT;
            idx_d   = idx_q + 24'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      done_q        <= 1'b0;
      best_valid_q  <= 1'b0;
      best_core_q   <= '0;
      best_score_q  <= '1;
      best_result_q <= '0;
`ifdef CORE_POLL_TIMEOUT_EN
      wait_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      done_q        <= done_d;
      best_valid_q  <= best_valid_d;
      best_core_q   <= best_core_d;
      best_score_q  <= best_score_d;
      best_result_q <= best_result_d;
`ifdef CORE_POLL_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  // idx is only rewritten on sweep start, so the selection holds in IDLE
  assign core_selection_o = idx_q;
  assign save_selection_o = (state_q == S_SELECT);
  assign output_enable_o  = (state_q == S_WAIT);
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = done_q;
  assign best_valid_o     = best_valid_q;
  assign best_core_o      = best_core_q;
  assign best_score_o     = best_score_q;
  assign best_result_o    = best_result_q;
`ifdef CORE_POLL_TIMEOUT_EN
  assign timeout_count_o  = tmo_cnt_q;
`else
  assign timeout_count_o  = 8'd0;
`endif

endmodule

// File: tb/tb_core_poll_scheduler.sv
// Directed bench for core_poll_scheduler with 4 cores; the timeout case runs only
// when CORE_POLL_TIMEOUT_EN is defined.
module tb_core_poll_scheduler;

  localparam int NUM_CORES = 4;
  localparam int SCORE_W   = 10;
  localparam int RESULT_W  = 64;
  localparam int TMO       = 4;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                start_i = 1'b0;
  logic                abort_i = 1'b0;
  logic                result_valid_i = 1'b0;
  logic [SCORE_W-1:0]  score_i = '0;
  logic [RESULT_W-1:0] result_i = '0;
  logic [23:0]         core_selection_o;
  logic                save_selection_o;
  logic                output_enable_o;
  logic                busy_o;
  logic                done_o;
  logic                best_valid_o;
  logic [23:0]         best_core_o;
  logic [SCORE_W-1:0]  best_score_o;
  logic [RESULT_W-1:0] best_result_o;
  logic [7:0]          timeout_count_o;

  core_poll_scheduler #(
    .NUM_CORES(NUM_CORES), .SCORE_W(SCORE_W), .RESULT_W(RESULT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .result_valid_i(result_valid_i), .score_i(score_i), .result_i(result_i),
    .core_selection_o(core_selection_o), .save_selection_o(save_selection_o),
    .output_enable_o(output_enable_o), .busy_o(busy_o), .done_o(done_o),
    .best_valid_o(best_valid_o), .best_core_o(best_core_o), .best_score_o(best_score_o),
    .best_result_o(best_result_o), .timeout_count_o(timeout_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [SCORE_W-1:0]  score_tab [NUM_CORES];
  logic [RESULT_W-1:0] result_tab[NUM_CORES];
  logic [23:0]         skip_core = 24'hFFFFFF;
  int                  sel_log[$];
  int                  overlap_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    if (save_selection_o && output_enable_o) overlap_cnt++;
    if (save_selection_o) sel_log.push_back(int'(core_selection_o));
  endtask

  task automatic drive_resp();
    result_valid_i = output_enable_o && (core_selection_o != skip_core);
    score_i        = score_tab[core_selection_o[1:0]];
    result_i       = result_tab[core_selection_o[1:0]];
  endtask

  // Pulses start_i; cycle c counts edges after the edge that sampled start_i.
  task automatic run_sweep(input int budget, output int done_at, output int done_pulses);
    done_at = -1;
    done_pulses = 0;
    sel_log.delete();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    observe();
    drive_resp();
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_i);
      observe();
      if (done_o) begin
        done_pulses++;
        if (done_at < 0) done_at = c;
      end
      drive_resp();
      if (done_at >= 0 && c >= done_at + 3) break;
    end
    result_valid_i = 1'b0;
  endtask

  task automatic wait_core_wait(input logic [23:0] id, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_i);
      if (output_enable_o && core_selection_o == id) begin
        ok = 1'b1;
        break;
      end
      drive_resp();
    end
  endtask

  initial begin
    int  done_at, pulses, cnt_a, cnt_b;
    bit  ok;

    for (int i = 0; i < NUM_CORES; i++) result_tab[i] = 64'hA5A5_0000_0000_0000 + 64'(i * 17 + 1);
    score_tab[0] = 10'd9; score_tab[1] = 10'd3; score_tab[2] = 10'd7; score_tab[3] = 10'd3;

    #23;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_oe", 64'(output_enable_o), 64'd0);
    check("rst_best_score", 64'(best_score_o), 64'h3FF);
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_sel", 64'(core_selection_o), 64'd0);
    check("rst_best_valid", 64'(best_valid_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);

    // scores 9,3,7,3
    run_sweep(60, done_at, pulses);
    check("a_done_at", 64'(done_at), 64'd8);
    check("a_done_pulses", 64'(pulses), 64'd1);
    check("a_best_valid", 64'(best_valid_o), 64'd1);
    check("a_best_core", 64'(best_core_o), 64'd1);
    check("a_best_score", 64'(best_score_o), 64'd3);
    check("a_best_result", best_result_o, result_tab[1]);
    check("a_overlap", 64'(overlap_cnt), 64'd0);
    check("a_strobes", 64'(sel_log.size()), 64'd4);
    for (int i = 0; i < sel_log.size(); i++) check("a_sel_seq", 64'(sel_log[i]), 64'(i));
    check("a_idle_sel_hold", 64'(core_selection_o), 64'd3);
    check("a_timeouts", 64'(timeout_count_o), 64'd0);
    repeat (5) @(negedge clk_i);
    check("a_best_stable", 64'(best_score_o), 64'd3);
    check("a_idle_busy", 64'(busy_o), 64'd0);

    // all scores all-ones
    for (int i = 0; i < NUM_CORES; i++) score_tab[i] = 10'h3FF;
    run_sweep(60, done_at, pulses);
    check("ones_valid", 64'(best_valid_o), 64'd1);
    check("ones_core", 64'(best_core_o), 64'd0);
    check("ones_score", 64'(best_score_o), 64'h3FF);
    check("ones_result", best_result_o, result_tab[0]);

    // abort with start and valid in core 2 WAIT
    score_tab[0] = 10'd9; score_tab[1] = 10'd3; score_tab[2] = 10'd7; score_tab[3] = 10'd3;
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    wait_core_wait(24'd2, ok);
    check("ab_reached", 64'(ok), 64'd1);
    check("ab_pre_valid", 64'(best_valid_o), 64'd1);
    abort_i = 1'b1; start_i = 1'b1; result_valid_i = 1'b1; score_i = 10'd0;
    @(negedge clk_i);
    abort_i = 1'b0; start_i = 1'b0; result_valid_i = 1'b0;
    check("ab_busy", 64'(busy_o), 64'd0);
    check("ab_oe", 64'(output_enable_o), 64'd0);
    check("ab_best_valid", 64'(best_valid_o), 64'd0);
    check("ab_best_score", 64'(best_score_o), 64'd3);
    cnt_a = int'(done_o);
    repeat (4) begin
      @(negedge clk_i);
      cnt_a += int'(done_o);
    end
    check("ab_no_done", 64'(cnt_a), 64'd0);
    run_sweep(60, done_at, pulses);
    check("ab_restart_first", 64'(sel_log.size() > 0 ? sel_log[0] : -1), 64'd0);
    check("ab_restart_done", 64'(done_at), 64'd8);
    check("ab_restart_core", 64'(best_core_o), 64'd1);

`ifdef CORE_POLL_TIMEOUT_EN
    skip_core = 24'd1;
    run_sweep(80, done_at, pulses);
    skip_core = 24'hFFFFFF;
    check("to_done_at", 64'(done_at), 64'd11);
    check("to_count", 64'(timeout_count_o), 64'd1);
    check("to_best_core", 64'(best_core_o), 64'd3);
    check("to_best_score", 64'(best_score_o), 64'd3);
`endif

    // async reset during WAIT
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    wait_core_wait(24'd1, ok);
    check("rw_reached", 64'(ok), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rw_oe", 64'(output_enable_o), 64'd0);
    check("rw_busy", 64'(busy_o), 64'd0);
    check("rw_sel", 64'(core_selection_o), 64'd0);
    check("rw_best_valid", 64'(best_valid_o), 64'd0);
    check("rw_best_score", 64'(best_score_o), 64'h3FF);
    result_valid_i = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    cnt_a = 0; cnt_b = 0;
    repeat (6) begin
      @(negedge clk_i);
      cnt_a += int'(busy_o);
      cnt_b += int'(save_selection_o) + int'(done_o);
    end
    check("rw_idle_busy", 64'(cnt_a), 64'd0);
    check("rw_idle_activity", 64'(cnt_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
